writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Final pipeline stage of the pipelined ARM core. Produces RegWriteW / WA3W / ResultW, which the decode stage uses to write its register file.
- Holds the memory→writeback pipeline register and selects the result.
- Detects retiring writes to r15 (or branch-taken retires), pulses the PC redirect, and squashes the wrong-path instructions that follow.

Parameters:
- SQUASH_CYCLES, 2: number of advancing slots squashed after a PC redirect; legal range 1..15.
- CNT_W, 32: width of the retire counter (optional feature).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- StallW  in  1  hold the W register.
- FlushW  in  1  load a bubble into the W register.
- ValidM  in  1  M-stage entry is a real instruction.
- RegWriteM  in  1  instruction writes a register.
- MemToRegM  in  1  result comes from memory read data.
- PCSrcM  in  1  instruction is a taken branch.
- WA3M  in  4  destination register.
- ALUOutM  in  32  ALU result.
- ReadDataM  in  32  data-memory read data.
- RegWriteW  out  1  register-file write enable.
- WA3W  out  4  register-file write address.
- ResultW  out  32  register-file write data.
- PCSrcW  out  1  one-cycle PC redirect to fetch.
- ResultValidW  out  1  W entry is live; used for forwarding qualification.
- SquashingW  out  1  FSM is in the SQUASH state.
- RetireCountW  out  CNT_W  retired-instruction count (present only with the optional feature).

Behaviour:
- **W register:** fields validW, regwrW, m2rW, pcsW, wa3W, aluW, rdW.
  - Updated on each rising clk edge.
  - FlushW=1: all fields load 0. Flush wins over stall.
  - Else StallW=1: all fields hold.
  - Else: all fields load the M inputs.
- **Reset:** asynchronous on reset=0. Clears all W fields, FSM→RUN, squash counter=0, RetireCountW=0. Consequently every output is 0 during reset, including ResultW=0.
- **Result select:** ResultW = m2rW ? rdW : aluW. Combinational from the W register, so latency is one clock from M inputs to W outputs. WA3W = wa3W.
- **Live / retire:**
  - live = validW & (state==RUN). ResultValidW = live. SquashingW = (state==SQUASH).
  - RegWriteW = live & regwrW. It stays asserted across stall cycles; the repeated write is idempotent.
  - retire = live & !StallW, i.e. the instruction leaves W this cycle.
  - redirect = retire & (pcsW | (regwrW & wa3W==4'd15)).
  - PCSrcW = redirect. This is a single pulse even if the entry sat stalled for several cycles beforehand.
- **FSM, two states:**
  - RUN: on redirect → SQUASH and load cnt = SQUASH_CYCLES. Otherwise stay in RUN.
  - SQUASH:
    - Every cycle with StallW=0 decrements cnt (one wrong-path slot consumed).
    - When cnt==1 and StallW=0 → RUN.
    - StallW=1 holds both cnt and state.
    - While in SQUASH, valid entries produce no RegWriteW, no PCSrcW and no retire. A r15 write or branch arriving during SQUASH is silently discarded.
  - FlushW has no effect on the FSM or cnt.
  - The write to r15 itself is performed: RegWriteW=1 in the redirect cycle.
- **Bubbles:** validW=0 never writes, never redirects, never retires. A bubble still consumes a squash slot if StallW=0.
- **Back-to-back:** an instruction entering W in the cycle the FSM returns to RUN is live.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- Defined:
  - RetireCountW port and CNT_W-bit counter are present.
  - Counter increments by 1 on each retire.
  - Wraps from all-ones to 0.
  - Squashed entries and bubbles are not counted.
- Undefined: the port and counter are absent and there is no other behavioural difference.

Test Plan:
- **Reset and select:** reset=0 mid-operation → all outputs 0 asynchronously. After release, load ValidM=1, RegWriteM=1, MemToRegM=0, WA3M=3, ALUOutM=0x11, ReadDataM=0x22 → next cycle RegWriteW=1, WA3W=3, ResultW=0x11. Repeat with MemToRegM=1 → ResultW=0x22.
- **Stall/flush:**
  - StallW=1 for 3 cycles with an entry in W → outputs hold and RegWriteW stays 1. With WB_RETIRE_COUNT_EN, RetireCountW increments exactly once.
  - StallW=1 and FlushW=1 together → bubble: RegWriteW=0, ResultW=0.
- **Redirect via r15:** retire RegWriteM=1, WA3M=15 → PCSrcW high for exactly 1 cycle with RegWriteW=1. The next 2 valid writes (WA3=1, 2) → RegWriteW=0 and SquashingW=1. The third (WA3=4) writes normally.
- **Squash under stall:** PCSrcM=1 retires, then StallW=1 for 4 cycles during SQUASH → SquashingW stays 1 and cnt holds. After release, exactly 2 unstalled slots are squashed.
- **Redirect inside squash:** a second PCSrcM=1 entry arrives in SQUASH → no PCSrcW pulse, and the FSM returns to RUN on the original schedule.
- **Counter wrap:** with CNT_W=4 and WB_RETIRE_COUNT_EN defined, retire 17 instructions → RetireCountW=1.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Memory->writeback bus for writeback_stage.
// master: the M stage / fetch / decode side that drives M-stage fields and
// consumes the register-file write and PC redirect.
// slave: the writeback stage itself.
// RetireCountW exists only when WB_RETIRE_COUNT_EN is defined.
interface writeback_stage_if #(parameter int CNT_W = 32);
  logic             StallW;
  logic             FlushW;
  logic             ValidM;
  logic             RegWriteM;
  logic             MemToRegM;
  logic             PCSrcM;
  logic [3:0]       WA3M;
  logic [31:0]      ALUOutM;
  logic [31:0]      ReadDataM;
  logic             RegWriteW;
  logic [3:0]       WA3W;
  logic [31:0]      ResultW;
  logic             PCSrcW;
  logic             ResultValidW;
  logic             SquashingW;
`ifdef WB_RETIRE_COUNT_EN
  logic [CNT_W-1:0] RetireCountW;
`endif

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, MemToRegM, PCSrcM, WA3M, ALUOutM, ReadDataM,
`ifdef WB_RETIRE_COUNT_EN
    input  RetireCountW,
`endif
    input  RegWriteW, WA3W, ResultW, PCSrcW, ResultValidW, SquashingW
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, MemToRegM, PCSrcM, WA3M, ALUOutM, ReadDataM,
`ifdef WB_RETIRE_COUNT_EN
    output RetireCountW,
`endif
    output RegWriteW, WA3W, ResultW, PCSrcW, ResultValidW, SquashingW
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage of the pipelined ARM core.
// Holds the M->W pipeline register, selects the result, pulses a PC redirect
// when a r15 write or taken branch retires, then squashes the next
// SQUASH_CYCLES advancing slots (wrong-path instructions).
// Optional retire counter: define WB_RETIRE_COUNT_EN.
module writeback_stage #(
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic clk,
  input  logic reset,
  writeback_stage_if.slave wb
);

  typedef struct packed {
    logic        valid;
    logic        regwr;
    logic        m2r;
    logic        pcs;
    logic [3:0]  wa3;
    logic [31:0] alu;
    logic [31:0] rd;
  } wreg_t;

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

  wreg_t      m_in, w_q;
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       live, retire, redirect;

  assign m_in = '{valid: wb.ValidM, regwr: wb.RegWriteM, m2r: wb.MemToRegM,
                  pcs: wb.PCSrcM, wa3: wb.WA3M, alu: wb.ALUOutM, rd: wb.ReadDataM};

  // W pipeline register: flush beats stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            w_q <= '0;
    else if (wb.FlushW)    w_q <= '0;
    else if (!wb.StallW)   w_q <= m_in;
  end

  // Entry is live only outside the squash window; it retires when W advances
  assign live     = w_q.valid & (state == RUN);
  assign retire   = live & ~wb.StallW;
  assign redirect = retire & (w_q.pcs | (w_q.regwr & (w_q.wa3 == 4'd15)));

  // Squash FSM state and slot counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: every unstalled slot in SQUASH burns one count, stall freezes it
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (redirect) begin
          state_nxt = SQUASH;
          cnt_nxt   = SQ_LOAD;
        end
      end
      SQUASH: begin
        if (!wb.StallW) begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign wb.ResultW      = w_q.m2r ? w_q.rd : w_q.alu;
  assign wb.WA3W         = w_q.wa3;
  assign wb.RegWriteW    = live & w_q.regwr;
  assign wb.PCSrcW       = redirect;
  assign wb.ResultValidW = live;
  assign wb.SquashingW   = (state == SQUASH);

`ifdef WB_RETIRE_COUNT_EN
  logic [CNT_W-1:0] ret_cnt;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ret_cnt <= '0;
    else if (retire) ret_cnt <= ret_cnt + 1'b1;
  end

  assign wb.RetireCountW = ret_cnt;
`endif

endmodule
